// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the round-robin pick function for the arbitrated N:1 bit mux.
// The pick function works on a fixed maximum width so one copy serves any N up to PICK_MAX_N.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned PICK_MAX_N = 32;
    localparam int unsigned PICK_IW    = 5;

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] idx;
    } pick_t;

    // Scan ptr+1, ptr+2, ... (mod n) and return the first asserted request.
    // The loop walks the order backwards, so the earliest match is the one written last.
    function automatic pick_t rr_pick(input logic [PICK_MAX_N-1:0] req,
                                      input int unsigned           ptr,
                                      input int unsigned           n);
        pick_t       res;
        int unsigned k;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = n; i >= 1; i--) begin
            k = ptr + i;
            if (k >= n) begin
                k = k - n;
            end
            if (req[k[PICK_IW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = k[PICK_IW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bus of the arbitrated mux: requests and data in, grant, select and muxed bit out.
interface rr_mux_arbiter_if #(
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  d;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          y;
    logic          busy;

    modport master (output req, output d, input gnt, input sel, input y, input busy);
    modport slave  (input req, input d, output gnt, output sel, output y, output busy);
endinterface

// File: rtl/rr_mux_arbiter_mux_n1.sv
// Plain N:1 bit multiplexer; the arbiter owns the select and gates the output.
module mux_n1 #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_d,
    input  logic [SW-1:0] i_sel,
    output logic          o_y
);
    assign o_y = i_d[i_sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of an N:1 bit mux; grants are held, fair and
// bounded to MAX_HOLD cycles whenever another requester is waiting.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_mux_arbiter_if.slave bus
);
    localparam int SW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    r_state;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_ptr;
    logic [N-1:0]  r_gnt;
    logic          r_busy;
    logic [HW-1:0] r_hold;

    logic [N-1:0]            w_others;
    logic [PICK_MAX_N-1:0]   w_req_ext;
    pick_t                   w_pick;
    logic [SW-1:0]           w_pick_idx;
    logic [N-1:0]            w_gnt_next;
    logic                    w_release;
    logic                    w_issue;
    logic                    w_to_idle;
    logic                    w_mux_y;
    logic                    w_unused_pick;

    // The holder is masked out so it lands last in the scan order when it is preempted.
    assign w_others = bus.req & ~r_gnt;

    always_comb begin
        w_req_ext         = '0;
        w_req_ext[N-1:0]  = w_others;
    end

    assign w_pick        = rr_pick(w_req_ext, int'(r_ptr), N);
    assign w_pick_idx    = w_pick.idx[SW-1:0];
    assign w_unused_pick = &{1'b0, w_pick.idx[PICK_IW-1:SW]};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gnt_decode
            assign w_gnt_next[gi] = (w_pick_idx == SW'(gi));
        end
    endgenerate

    assign w_release = !bus.req[r_sel] || ((r_hold == HOLD_LAST) && (|w_others));
    assign w_issue   = w_pick.found && ((r_state == IDLE) || w_release);
    assign w_to_idle = (r_state == GRANT) && w_release && !w_pick.found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= SW'(N - 1);
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE, GRANT: begin
                    if (w_issue) begin
                        r_state <= GRANT;
                        r_sel   <= w_pick_idx;
                        r_ptr   <= w_pick_idx;
                        r_gnt   <= w_gnt_next;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end else if (w_to_idle) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_hold  <= '0;
                    end else if ((r_state == GRANT) && (r_hold != HOLD_LAST)) begin
                        r_hold  <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    mux_n1 #(
        .N  (N),
        .SW (SW)
    ) u_mux (
        .i_d   (bus.d),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    assign bus.gnt  = r_gnt;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
    assign bus.y    = w_mux_y & r_busy;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and constrained-random checks of the round-robin mux arbiter (N=4, MAX_HOLD=8).
module tb_rr_mux_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N(N)) bus ();

    rr_mux_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.d   = 4'b1111;
        tick();
        tick();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.sel !== 2'd0)    begin bad++; $display("FAIL reset_sel got=%0d want=0", bus.sel); end
        total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.y !== 1'b0)      begin bad++; $display("FAIL reset_y got=%b want=0", bus.y); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b want=0001", bus.gnt); end
        total++; if (bus.sel !== 2'd0)    begin bad++; $display("FAIL reset_first_sel got=%0d want=0", bus.sel); end
        total++; if (bus.y !== 1'b1)      begin bad++; $display("FAIL reset_first_y got=%b want=1", bus.y); end
        bus.req = 4'b0000;
        tick();
        total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.y !== 1'b0)      begin bad++; $display("FAIL idle_y got=%b want=0", bus.y); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        bus.d   = 4'b0100;
        tick();
        for (int c = 0; c < 20; c++) begin
            total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt cyc=%0d got=%b want=0100", c, bus.gnt); end
            total++; if (bus.sel !== 2'd2)    begin bad++; $display("FAIL single_sel cyc=%0d got=%0d want=2", c, bus.sel); end
            total++; if (bus.y !== 1'b1)      begin bad++; $display("FAIL single_y cyc=%0d got=%b want=1", c, bus.y); end
            tick();
        end
        bus.req = 4'b0000;
        tick();
        $display("test_single: 20 held cycles checked");
    endtask

    task automatic test_rotate();
        logic [3:0] seq [5];
        logic [3:0] dval;
        logic       yexp;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        rst_n = 1'b0;
        #2;
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        bus.d   = 4'b1010;
        dval    = 4'b1010;
        tick();
        for (int g = 0; g < 5; g++) begin
            yexp = |(seq[g] & dval);
            for (int c = 0; c < MAX_HOLD; c++) begin
                total++; if (bus.gnt !== seq[g]) begin bad++; $display("FAIL rotate_gnt slot=%0d cyc=%0d got=%b want=%b", g, c, bus.gnt, seq[g]); end
                total++; if (bus.y !== yexp)     begin bad++; $display("FAIL rotate_y slot=%0d cyc=%0d got=%b want=%b", g, c, bus.y, yexp); end
                tick();
            end
            $display("test_rotate: slot %0d grant %b held %0d cycles", g, seq[g], MAX_HOLD);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_holder_drop();
        bus.req = 4'b0001;
        bus.d   = 4'b0000;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL drop_start_gnt got=%b want=0001", bus.gnt); end
        bus.req = 4'b1010;
        tick();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL drop_first_gnt got=%b want=0010", bus.gnt); end
        total++; if (bus.sel !== 2'd1)    begin bad++; $display("FAIL drop_first_sel got=%0d want=1", bus.sel); end
        bus.req = 4'b1000;
        tick();
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL drop_second_gnt got=%b want=1000", bus.gnt); end
        total++; if (bus.busy !== 1'b1)   begin bad++; $display("FAIL drop_second_busy got=%b want=1", bus.busy); end
        bus.req = 4'b0000;
        tick();
        total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL drop_idle_busy got=%b want=0", bus.busy); end
        $display("test_holder_drop: done");
    endtask

    task automatic test_async_reset();
        bus.req = 4'b0100;
        bus.d   = 4'b0100;
        tick();
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL areset_pre_gnt got=%b want=0100", bus.gnt); end
        total++; if (bus.sel !== 2'd2)    begin bad++; $display("FAIL areset_pre_sel got=%0d want=2", bus.sel); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL areset_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.sel !== 2'd0)    begin bad++; $display("FAIL areset_sel got=%0d want=0", bus.sel); end
        total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL areset_busy got=%b want=0", bus.busy); end
        total++; if (bus.y !== 1'b0)      begin bad++; $display("FAIL areset_y got=%b want=0", bus.y); end
        bus.req = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL areset_first_gnt got=%b want=0001", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        $display("test_async_reset: done");
    endtask

    task automatic test_random();
        int         waitc [N];
        logic [N-1:0] nr;
        logic       yexp;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i])     nr[i] = ($urandom_range(2) == 0);
                else if (bus.gnt[i]) nr[i] = ($urandom_range(3) != 0);
                else                 nr[i] = 1'b1;
            end
            bus.req = nr;
            bus.d   = N'($urandom);
            tick();
            yexp = bus.busy ? bus.d[bus.sel] : 1'b0;
            total++; if (!$onehot0(bus.gnt)) begin bad++; $display("FAIL rand_onehot cyc=%0d got=%b want=onehot0", cyc, bus.gnt); end
            total++; if (bus.y !== yexp)     begin bad++; $display("FAIL rand_y cyc=%0d got=%b want=%b", cyc, bus.y, yexp); end
            total++; if (bus.busy !== (|bus.gnt)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, bus.busy, |bus.gnt); end
            if (bus.busy) begin
                total++; if (bus.gnt !== (N'(1) << bus.sel)) begin bad++; $display("FAIL rand_gnt_sel cyc=%0d gnt=%b sel=%0d", cyc, bus.gnt, bus.sel); end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !bus.gnt[i]) waitc[i]++;
                else                           waitc[i] = 0;
                total++; if (waitc[i] > (N-1)*MAX_HOLD) begin bad++; $display("FAIL rand_starve cyc=%0d req=%0d waited=%0d max=%0d", cyc, i, waitc[i], (N-1)*MAX_HOLD); end
            end
        end
        bus.req = '0;
        tick();
        $display("test_random: 1000 cycles checked");
    endtask

    initial begin
        bus.req = '0;
        bus.d   = '0;
        test_reset();
        test_single();
        test_rotate();
        test_holder_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
